// File: rtl/gps_csrbrg_pkg.sv
// Shared CSR-bus definitions for the GPS-SDR bridge and its ctlif slaves.
// Pure declarations: no latency, no flow control.
package gps_csr_pkg;

  localparam int CSR_AW      = 15;
  localparam int CSR_DW      = 32;
  localparam int CSR_SEL_MSB = 14;
  localparam int CSR_SEL_LSB = 10;
  localparam int WB_AW       = 32;
  localparam int WB_DW       = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // Core-select values carried in csr_a[14:10]
  localparam logic [4:0] GPS_CTL = 5'h0;
  localparam logic [4:0] GPS_RX0 = 5'h1;
  localparam logic [4:0] GPS_RX1 = 5'h2;
  localparam logic [4:0] GPS_ACQ = 5'h3;

  // Wishbone byte address -> CSR word address (bits [16:2])
  function automatic logic [CSR_AW-1:0] wb_to_csr_adr(input logic [WB_AW-1:0] adr);
    return adr[CSR_AW+1:2];
  endfunction

  function automatic logic [4:0] csr_core_sel(input logic [CSR_AW-1:0] a);
    return a[CSR_SEL_MSB:CSR_SEL_LSB];
  endfunction

endpackage

// File: rtl/gps_csrbrg_if.sv
// Wishbone classic and CSR bus bundles used by gps_csrbrg.
// Plain wiring: no latency; Wishbone stalls by withholding ack, CSR has none.
interface gps_wb_if;
  import gps_csr_pkg::*;

  logic [WB_AW-1:0] wb_adr_i;
  logic [WB_DW-1:0] wb_dat_i;
  logic [WB_DW-1:0] wb_dat_o;
  logic             wb_cyc_i;
  logic             wb_stb_i;
  logic             wb_we_i;
  logic             wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

interface gps_csr_if;
  import gps_csr_pkg::*;

  logic [CSR_AW-1:0] csr_a;
  logic              csr_we;
  logic [CSR_DW-1:0] csr_di;
  logic [CSR_DW-1:0] csr_do;

  modport master (
    output csr_a, csr_we, csr_di,
    input  csr_do
  );

  modport slave (
    input  csr_a, csr_we, csr_di,
    output csr_do
  );
endinterface

// File: rtl/gps_csrbrg.sv
// Wishbone-slave to CSR-initiator bridge; write acked in 2 cycles, read in 2+RD_LATENCY.
// Wishbone master is stalled until ack; CSR side has no backpressure, dropped CYC suppresses ack.
module gps_csrbrg
  import gps_csr_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  gps_wb_if.slave    wb,
  gps_csr_if.master  csr
);

  if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
    $error("gps_csrbrg: RD_LATENCY must be within 1..7");
  end

  // READ spans the address-setup cycle plus RD_LATENCY slave cycles
  localparam logic [2:0] LAT_LD = 3'(RD_LATENCY);

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic [CSR_AW-1:0] r_csr_a;
  logic [CSR_DW-1:0] r_csr_di;
  logic              r_csr_we;
  logic [WB_DW-1:0]  r_dat_o;
  logic              r_ack;
  logic              r_abort;

  state_t            w_state_nxt;
  logic [2:0]        w_cnt_nxt;
  logic [CSR_AW-1:0] w_csr_a_nxt;
  logic [CSR_DW-1:0] w_csr_di_nxt;
  logic              w_csr_we_nxt;
  logic [WB_DW-1:0]  w_dat_nxt;
  logic              w_ack_nxt;
  logic              w_abort_nxt;
  logic              w_req;
  logic              w_unused_adr;

  assign w_req        = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
  assign w_unused_adr = ^{wb.wb_adr_i[WB_AW-1:CSR_AW+2], wb.wb_adr_i[1:0]};

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_csr_a_nxt  = r_csr_a;
    w_csr_di_nxt = r_csr_di;
    w_csr_we_nxt = 1'b0;
    w_dat_nxt    = r_dat_o;
    w_ack_nxt    = 1'b0;
    w_abort_nxt  = r_abort;

    unique case (r_state)
      ST_IDLE: begin
        w_abort_nxt = 1'b0;
        if (w_req) begin
          w_csr_a_nxt  = wb_to_csr_adr(wb.wb_adr_i);
          w_csr_di_nxt = wb.wb_dat_i;
          if (wb.wb_we_i) begin
            w_csr_we_nxt = 1'b1;
            w_state_nxt  = ST_WRITE;
          end else begin
            w_cnt_nxt    = LAT_LD;
            w_state_nxt  = ST_READ;
          end
        end
      end

      ST_WRITE: begin
        if (wb.wb_cyc_i && !r_abort) begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_ACK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_READ: begin
        // An abort seen at any point of the read wait kills the ack
        if (!wb.wb_cyc_i) begin
          w_abort_nxt = 1'b1;
        end
        if (r_cnt != 3'd0) begin
          w_cnt_nxt = r_cnt - 3'd1;
        end else if (wb.wb_cyc_i && !r_abort) begin
          w_dat_nxt   = csr.csr_do;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_ACK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_csr_a  <= '0;
      r_csr_di <= '0;
      r_csr_we <= 1'b0;
      r_dat_o  <= '0;
      r_ack    <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_csr_a  <= w_csr_a_nxt;
      r_csr_di <= w_csr_di_nxt;
      r_csr_we <= w_csr_we_nxt;
      r_dat_o  <= w_dat_nxt;
      r_ack    <= w_ack_nxt;
      r_abort  <= w_abort_nxt;
    end
  end

  assign csr.csr_a    = r_csr_a;
  assign csr.csr_di   = r_csr_di;
  assign csr.csr_we   = r_csr_we;
  assign wb.wb_dat_o  = r_dat_o;
  assign wb.wb_ack_o  = r_ack;

endmodule
